// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one-at-a-time word reads to
// instruction memory and buffers returned words for decode in a small FIFO.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirectValid,
  input  logic [31:0] redirectPC,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] instrPC,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  // Handshakes: memory transfer happens on a posedge with memReq && memAck;
  // memReq/memAddr never change while a request waits for its ack. Decode
  // transfer happens on a posedge with instrValid && instrReady.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    STALL   = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  fetchState_t state, stateNext;
  logic [31:0] fetchPC, fetchPCNext, memAddrNext;
  logic        memReqNext, push, pop, flush, ackFire;
  logic [31:0] instrMem [FIFO_DEPTH];
  logic [31:0] pcMem    [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count, countPlus;

  assign ackFire    = memReq & memAck;
  assign instrValid = (count != '0);
  assign pop        = instrValid & instrReady;
  assign countPlus  = count + 1'b1;
  assign busy       = (state != FETCH);
  assign instr      = instrValid ? instrMem[rdPtr] : '0;
  assign instrPC    = instrValid ? pcMem[rdPtr]    : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      fetchPC <= RESET_PC;
      memReq  <= 1'b0;
      memAddr <= RESET_PC;
    end else begin
      state   <= stateNext;
      fetchPC <= fetchPCNext;
      memReq  <= memReqNext;
      memAddr <= memAddrNext;
    end
  end

  always_comb begin
    stateNext   = state;
    fetchPCNext = fetchPC;
    memReqNext  = memReq;
    memAddrNext = memAddr;
    push        = 1'b0;
    flush       = 1'b0;
    if (redirectValid) begin
      flush       = 1'b1;
      fetchPCNext = redirectPC;
      if (memReq && !memAck) begin
        // Outstanding request must complete before the new target is fetched.
        stateNext = DISCARD;
      end else begin
        stateNext   = FETCH;
        memReqNext  = 1'b1;
        memAddrNext = redirectPC;
      end
    end else begin
      case (state)
        FETCH: begin
          if (ackFire) begin
            push        = 1'b1;
            fetchPCNext = fetchPC + 32'd1;
            if (countPlus < FULL) begin
              memReqNext  = 1'b1;
              memAddrNext = fetchPC + 32'd1;
            end else begin
              memReqNext = 1'b0;
              if (!pop) stateNext = STALL;
            end
          end else if (!memReq) begin
            if (count < FULL) begin
              memReqNext  = 1'b1;
              memAddrNext = fetchPC;
            end else begin
              stateNext = STALL;
            end
          end
        end
        STALL: begin
          if (pop) stateNext = FETCH;
        end
        DISCARD: begin
          if (ackFire) begin
            stateNext   = FETCH;
            memReqNext  = 1'b1;
            memAddrNext = fetchPC;
          end
        end
        default: stateNext = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      instrMem[wrPtr] <= memData;
      pcMem[wrPtr]    <= fetchPC;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed cycle-by-cycle bench for instruction_fetch_unit: a table of
// per-edge stimulus and expected outputs plus a mid-request reset sequence.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] instrPC;
  logic        busy;

  int errCount   = 0;
  int checkCount = 0;

  always #5 clock = ~clock;

  instruction_fetch_unit #(.RESET_PC(32'd0), .FIFO_DEPTH(2)) dut (
    .clock(clock),
    .reset(reset),
    .redirectValid(redirectValid),
    .redirectPC(redirectPC),
    .memReq(memReq),
    .memAddr(memAddr),
    .memAck(memAck),
    .memData(memData),
    .instrValid(instrValid),
    .instrReady(instrReady),
    .instr(instr),
    .instrPC(instrPC),
    .busy(busy)
  );

  // Memory content is a fixed scramble of the address.
  function automatic logic [31:0] wordOf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  assign memData = wordOf(memAddr);

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic        rdy;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] ePC;
    logic        eBusy;
  } vec_t;

  vec_t tbl [33];

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc,
                              input logic ack, input logic rdy,
                              input logic eReq, input logic [31:0] eAddr,
                              input logic eValid, input logic [31:0] ePC,
                              input logic eBusy);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdy = rdy;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.ePC = ePC;
    v.eBusy = eBusy;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic checkOut(input string tag, input logic eReq,
                          input logic [31:0] eAddr, input logic eValid,
                          input logic [31:0] ePC, input logic eBusy);
    logic [31:0] eInstr;
    eInstr = eValid ? wordOf(ePC) : 32'd0;
    cmp({tag, ".memReq"},     {31'd0, memReq},     {31'd0, eReq});
    cmp({tag, ".memAddr"},    memAddr,             eAddr);
    cmp({tag, ".instrValid"}, {31'd0, instrValid}, {31'd0, eValid});
    cmp({tag, ".instrPC"},    instrPC,             ePC);
    cmp({tag, ".instr"},      instr,               eInstr);
    cmp({tag, ".busy"},       {31'd0, busy},       {31'd0, eBusy});
  endtask

  task automatic runVec(input int idx);
    redirectValid = tbl[idx].rv;
    redirectPC    = tbl[idx].rpc;
    memAck        = tbl[idx].ack;
    instrReady    = tbl[idx].rdy;
    @(posedge clock);
    #1;
    checkOut($sformatf("vec%0d", idx), tbl[idx].eReq, tbl[idx].eAddr,
             tbl[idx].eValid, tbl[idx].ePC, tbl[idx].eBusy);
  endtask

  // One word buffered and a request to 0x21 pending when reset hits mid-cycle.
  task automatic resetMidRequest();
    #2;
    redirectValid = 1'b0;
    memAck        = 1'b0;
    instrReady    = 1'b0;
    reset         = 1'b1;
    #1;
    checkOut("asyncReset", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(posedge clock);
    #1;
    checkOut("heldReset", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    //             rv  rpc           ack rdy req addr          vld pc            busy
    // streaming from reset, then FIFO fill/stall/drain
    tbl[0]  = mk(0, 32'd0,        1, 1, 1, 32'd0,        0, 32'd0,        0);
    tbl[1]  = mk(0, 32'd0,        1, 1, 1, 32'd1,        1, 32'd0,        0);
    tbl[2]  = mk(0, 32'd0,        1, 1, 0, 32'd1,        1, 32'd1,        0);
    tbl[3]  = mk(0, 32'd0,        1, 1, 1, 32'd2,        0, 32'd0,        0);
    tbl[4]  = mk(0, 32'd0,        1, 1, 1, 32'd3,        1, 32'd2,        0);
    tbl[5]  = mk(0, 32'd0,        1, 0, 0, 32'd3,        1, 32'd2,        1);
    tbl[6]  = mk(0, 32'd0,        1, 0, 0, 32'd3,        1, 32'd2,        1);
    tbl[7]  = mk(0, 32'd0,        1, 1, 0, 32'd3,        1, 32'd3,        0);
    tbl[8]  = mk(0, 32'd0,        1, 0, 1, 32'd4,        1, 32'd3,        0);
    tbl[9]  = mk(0, 32'd0,        1, 0, 0, 32'd4,        1, 32'd3,        1);
    tbl[10] = mk(0, 32'd0,        0, 1, 0, 32'd4,        1, 32'd4,        0);
    tbl[11] = mk(0, 32'd0,        0, 1, 1, 32'd5,        0, 32'd0,        0);
    tbl[12] = mk(0, 32'd0,        0, 1, 1, 32'd5,        0, 32'd0,        0);
    // redirect with request pending: address held, word dropped
    tbl[13] = mk(1, 32'h40,       0, 1, 1, 32'd5,        0, 32'd0,        1);
    tbl[14] = mk(0, 32'd0,        0, 1, 1, 32'd5,        0, 32'd0,        1);
    tbl[15] = mk(0, 32'd0,        1, 1, 1, 32'h40,       0, 32'd0,        0);
    // redirect on the same edge as an ack
    tbl[16] = mk(1, 32'd7,        1, 1, 1, 32'd7,        0, 32'd0,        0);
    tbl[17] = mk(1, 32'h80,       1, 1, 1, 32'h80,       0, 32'd0,        0);
    tbl[18] = mk(0, 32'd0,        1, 0, 1, 32'h81,       1, 32'h80,       0);
    tbl[19] = mk(0, 32'd0,        0, 0, 1, 32'h81,       1, 32'h80,       0);
    // redirect flushes buffered word; repeated redirects in DISCARD
    tbl[20] = mk(1, 32'hFFFFFFFF, 0, 0, 1, 32'h81,       0, 32'd0,        1);
    tbl[21] = mk(1, 32'h90,       0, 0, 1, 32'h81,       0, 32'd0,        1);
    tbl[22] = mk(1, 32'hFFFFFFFF, 1, 0, 1, 32'hFFFFFFFF, 0, 32'd0,        0);
    // address wrap
    tbl[23] = mk(0, 32'd0,        1, 0, 1, 32'd0,        1, 32'hFFFFFFFF, 0);
    tbl[24] = mk(0, 32'd0,        1, 0, 0, 32'd0,        1, 32'hFFFFFFFF, 1);
    // redirect out of STALL (no request outstanding)
    tbl[25] = mk(1, 32'h20,       0, 0, 1, 32'h20,       0, 32'd0,        0);
    tbl[26] = mk(0, 32'd0,        1, 0, 1, 32'h21,       1, 32'h20,       0);
    // after mid-request reset: fill two words, stall, drain, resume at 2
    tbl[27] = mk(0, 32'd0,        1, 0, 1, 32'd0,        0, 32'd0,        0);
    tbl[28] = mk(0, 32'd0,        1, 0, 1, 32'd1,        1, 32'd0,        0);
    tbl[29] = mk(0, 32'd0,        1, 0, 0, 32'd1,        1, 32'd0,        1);
    tbl[30] = mk(0, 32'd0,        1, 0, 0, 32'd1,        1, 32'd0,        1);
    tbl[31] = mk(0, 32'd0,        0, 1, 0, 32'd1,        1, 32'd1,        0);
    tbl[32] = mk(0, 32'd0,        0, 1, 1, 32'd2,        0, 32'd0,        0);

    reset         = 1'b1;
    redirectValid = 1'b0;
    redirectPC    = 32'd0;
    memAck        = 1'b0;
    instrReady    = 1'b0;
    #3;
    checkOut("reset", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 33; i++) begin
      if (i == 27) resetMidRequest();
      runVec(i);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
